// File: rtl/noc_rx_endpoint.sv
// Receive-side NoC endpoint: ejection buffer, credit return, SOP marking and packet counting.
// Optional NOC_RX_DEST_CHECK_EN: discard flits whose dest differs from ENDPOINT_ID and flag err_dest.
module noc_rx_endpoint #(
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_WIDTH        = 256,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int ENDPOINT_ID       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] out_data,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic                  out_is_tail,
  output logic                  out_sop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           pkt_count,
  output logic                  err_overflow
`ifdef NOC_RX_DEST_CHECK_EN
  ,
  output logic                  err_dest
`endif
);

  localparam int PTR_W = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int CNT_W = $clog2(FLIT_BUFFER_DEPTH + 1);

  // Handshake: a flit transfers on a rising edge where out_valid and out_ready are both high;
  // out_valid never depends on out_ready, and out_* hold steady until the transfer.

  typedef enum logic [0:0] {
    PKT_IDLE = 1'b0,
    PKT_IN   = 1'b1
  } pkt_state_e;

  logic [FLIT_WIDTH-1:0] mem_data_q [FLIT_BUFFER_DEPTH];
  logic [DEST_WIDTH-1:0] mem_dest_q [FLIT_BUFFER_DEPTH];
  logic                  mem_tail_q [FLIT_BUFFER_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             credit_q;
  logic             overflow_q;
  logic [31:0]      pkt_count_q, pkt_count_d;
  pkt_state_e       state_q, state_d;

  logic head_valid;
  logic head_tail;
  logic head_misrouted;
  logic full;
  logic deliver;
  logic pop;
  logic push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FLIT_BUFFER_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign head_valid = (count_q != '0);
  assign full       = (count_q == CNT_W'(FLIT_BUFFER_DEPTH));
  assign head_tail  = mem_tail_q[rd_ptr_q];

`ifdef NOC_RX_DEST_CHECK_EN
  logic err_dest_q;

  assign head_misrouted = head_valid && (mem_dest_q[rd_ptr_q] != DEST_WIDTH'(ENDPOINT_ID));
  assign err_dest       = err_dest_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_dest_q <= 1'b0;
    end else if (head_misrouted) begin
      err_dest_q <= 1'b1;
    end
  end
`else
  logic unused_endpoint_id;

  assign head_misrouted     = 1'b0;
  assign unused_endpoint_id = ^DEST_WIDTH'(ENDPOINT_ID);
`endif

  // A misrouted head is dropped without waiting for the consumer.
  assign deliver = head_valid && !head_misrouted && out_ready;
  assign pop     = deliver || head_misrouted;
  // A full buffer still takes a flit when a slot frees on the same edge.
  assign push    = send_in && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pkt_count_d = pkt_count_q;
    case (state_q)
      PKT_IDLE: begin
        if (deliver) begin
          if (head_tail) begin
            pkt_count_d = pkt_count_q + 32'd1;
          end else begin
            state_d = PKT_IN;
          end
        end
      end
      PKT_IN: begin
        if (deliver && head_tail) begin
          state_d     = PKT_IDLE;
          pkt_count_d = pkt_count_q + 32'd1;
        end
      end
      default: state_d = PKT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
      pkt_count_q <= '0;
      state_q     <= PKT_IDLE;
      for (int i = 0; i < FLIT_BUFFER_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_dest_q[i] <= '0;
        mem_tail_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      credit_q    <= pop;
      pkt_count_q <= pkt_count_d;
      state_q     <= state_d;
      if (send_in && !push) begin
        overflow_q <= 1'b1;
      end
      if (push) begin
        mem_data_q[wr_ptr_q] <= data_in;
        mem_dest_q[wr_ptr_q] <= dest_in;
        mem_tail_q[wr_ptr_q] <= is_tail_in;
      end
    end
  end

  assign credit_out   = credit_q;
  assign out_valid    = head_valid && !head_misrouted;
  assign out_data     = mem_data_q[rd_ptr_q];
  assign out_dest     = mem_dest_q[rd_ptr_q];
  assign out_is_tail  = head_tail;
  assign out_sop      = (state_q == PKT_IDLE);
  assign pkt_count    = pkt_count_q;
  assign err_overflow = overflow_q;

endmodule
